// File: rtl/video_in_pkg.sv
// Shared video_in definitions: frame geometry defaults,
// store FSM states and the packed 4-pixel FIFO word.
package video_in_pkg;

    localparam int WIDTH_DEF       = 640;
    localparam int HEIGHT_DEF      = 480;
    localparam int WORDS_PER_FRAME = WIDTH_DEF * HEIGHT_DEF / 4;
    localparam int WCNT_W          = 17;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        BURST,
        END_FRAME
    } store_state_t;

    typedef union packed {
        logic [31:0]     word;
        logic [3:0][7:0] pix;
    } pix_word_u;

endpackage

// File: rtl/video_in_addr_gen.sv
// Frame-buffer address generator: base select, +4 per word,
// word counter and last-word flag.
// Ports: load (frame start), adv (word accepted), toggle
// (frame end), base0/base1 in; adr, last_word, buf_idx out.
// Build option: VIDEO_IN_STORE_DOUBLE_BUF_EN enables base1.
module video_in_addr_gen
    import video_in_pkg::*;
#(
    parameter int p_WORDS = WORDS_PER_FRAME
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        load,
    input  logic        adv,
    input  logic        toggle,
    input  logic [31:0] base0,
    input  logic [31:0] base1,
    output logic [31:0] adr,
    output logic        last_word,
    output logic        buf_idx
);

    logic [WCNT_W-1:0] word_cnt;
    logic              nxt_idx;
    logic [31:0]       base_sel;

`ifdef VIDEO_IN_STORE_DOUBLE_BUF_EN
    // A reload in the END_FRAME cycle must use the toggled index.
    assign nxt_idx  = buf_idx ^ toggle;
    assign base_sel = nxt_idx ? base1 : base0;
`else
    logic unused_dbuf;
    assign unused_dbuf = ^{base1, toggle};
    assign nxt_idx     = 1'b0;
    assign base_sel    = base0;
`endif

    assign last_word = (word_cnt == WCNT_W'(p_WORDS - 1));

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            adr      <= '0;
            word_cnt <= '0;
            buf_idx  <= 1'b0;
        end else begin
            buf_idx <= nxt_idx;
            if (load) begin
                adr      <= base_sel;
                word_cnt <= '0;
            end else if (adv) begin
                adr      <= adr + 32'd4;
                word_cnt <= word_cnt + WCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/video_in_store.sv
// video_in write side: drains the pixel FIFO into frame buffers
// with fixed-length Wishbone write bursts, pulses frame_done.
// Ports: clk/nRST, enable, base0/base1, FIFO (level/empty/data/rd),
// Wishbone master (cyc/stb/we/sel/adr/dat/ack), frame_done/done_buf.
// Build option: VIDEO_IN_STORE_DOUBLE_BUF_EN (ping-pong buffers).
module video_in_store
    import video_in_pkg::*;
#(
    parameter int p_WIDTH  = WIDTH_DEF,
    parameter int p_HEIGHT = HEIGHT_DEF,
    parameter int p_BURST  = 8,
    parameter int p_LVL_W  = 7
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               enable,
    input  logic [31:0]        base0,
    input  logic [31:0]        base1,
    input  logic [p_LVL_W-1:0] fifo_level,
    input  logic               fifo_empty,
    input  logic [31:0]        fifo_data,
    output logic               fifo_rd,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [3:0]         wb_sel_o,
    output logic [31:0]        wb_adr_o,
    output logic [31:0]        wb_dat_o,
    input  logic               wb_ack_i,
    output logic               frame_done,
    output logic               done_buf
);

    localparam int N_WORDS = p_WIDTH * p_HEIGHT / 4;
    localparam int BW      = (p_BURST > 1) ? $clog2(p_BURST) : 1;

    store_state_t  state, state_nxt;
    logic          lvl_ok;
    logic          ack_ok;
    logic          load;
    logic          toggle;
    logic          last_word;
    logic          buf_idx;
    logic          burst_last;
    logic [BW-1:0] burst_cnt;
    pix_word_u     head;

    // Bus outputs decode straight from the state flop, so reset
    // drops cyc/stb without waiting for a clock.
    assign wb_cyc_o   = (state == BURST);
    assign wb_stb_o   = (state == BURST);
    assign wb_we_o    = (state == BURST);
    assign wb_sel_o   = 4'hF;
    assign head       = fifo_data;
    assign wb_dat_o   = head.word;
    assign frame_done = (state == END_FRAME);

    // An ack against an empty FIFO is not a transfer.
    assign ack_ok     = wb_stb_o & wb_ack_i & ~fifo_empty;
    assign fifo_rd    = ack_ok;
    assign burst_last = (burst_cnt == BW'(p_BURST - 1));

`ifdef VIDEO_IN_STORE_DOUBLE_BUF_EN
    assign done_buf = frame_done & buf_idx;
`else
    logic unused_idx;
    assign unused_idx = buf_idx;
    assign done_buf   = 1'b0;
`endif

    video_in_addr_gen #(
        .p_WORDS (N_WORDS)
    ) u_addr_gen (
        .clk       (clk),
        .nRST      (nRST),
        .load      (load),
        .adv       (ack_ok),
        .toggle    (toggle),
        .base0     (base0),
        .base1     (base1),
        .adr       (wb_adr_o),
        .last_word (last_word),
        .buf_idx   (buf_idx)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        toggle    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    load      = 1'b1;
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (lvl_ok) state_nxt = BURST;
            end
            BURST: begin
                if (ack_ok && burst_last)
                    state_nxt = last_word ? END_FRAME : WAIT_DATA;
            end
            END_FRAME: begin
                toggle = 1'b1;
                if (enable) begin
                    load      = 1'b1;
                    state_nxt = WAIT_DATA;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // lvl_ok only samples while waiting, so the stale level seen
    // during a burst can never launch a short one.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            lvl_ok    <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lvl_ok <= (state == WAIT_DATA) &&
                      (fifo_level >= p_LVL_W'(p_BURST));
            if (load)
                burst_cnt <= '0;
            else if (ack_ok)
                burst_cnt <= burst_cnt + BW'(1);
        end
    end

`ifndef SYNTHESIS
    a_no_empty_in_burst: assert property (
        @(posedge clk) disable iff (!nRST)
        !(wb_stb_o && fifo_empty)
    ) else $error("video_in_store: FIFO empty during burst");
`endif

endmodule

// File: tb/tb_video_in_store.sv
// Directed bench for video_in_store with a 32x2 frame
// (16 words, two 8-word bursts per frame).
module tb_video_in_store;

    localparam int          NB = 8;
    localparam logic [31:0] B0 = 32'h1000_0000;
    localparam logic [31:0] B1 = 32'h2000_0000;
    localparam logic [31:0] DB = 32'hD000_0000;
`ifdef VIDEO_IN_STORE_DOUBLE_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        enable = 1'b0;
    logic [6:0]  fifo_level = '0;
    logic        fifo_empty = 1'b0;
    logic [31:0] fifo_data;
    logic        fifo_rd;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic        wb_ack_i = 1'b0;
    logic        frame_done, done_buf;

    int n_chk = 0;
    int n_fail = 0;
    int pops_total = 0;

    logic [31:0] obs_adr [NB];
    logic [31:0] obs_dat [NB];
    logic [31:0] obs_d0;
    int          obs_n, obs_pops, obs_bad;
    logic        obs_to, obs_cyc, obs_fd, obs_db;

    always #5 clk = ~clk;

    // FIFO model: head word advances on each pop.
    always @(posedge clk) if (fifo_rd) pops_total <= pops_total + 1;
    assign fifo_data = DB + 32'(pops_total);

    video_in_store #(
        .p_WIDTH (32),
        .p_HEIGHT(2),
        .p_BURST (NB),
        .p_LVL_W (7)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
        .enable    (enable),
        .base0     (B0),
        .base1     (B1),
        .fifo_level(fifo_level),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_i  (wb_ack_i),
        .frame_done(frame_done),
        .done_buf  (done_buf)
    );

    // Stimulus only: plays slave for one burst and records what it saw.
    task automatic do_burst(input int waits);
        int t;
        logic [31:0] a0, d0;
        t = 0; obs_n = 0; obs_pops = 0; obs_bad = 0; obs_to = 1'b0;
        a0 = '0; d0 = '0;
        obs_d0 = DB + 32'(pops_total);
        while (!wb_stb_o && t < 20) begin @(negedge clk); #1; t++; end
        if (!wb_stb_o) obs_to = 1'b1;
        while (wb_stb_o && obs_n < NB && t < 200) begin
            for (int w = 0; w < waits; w++) begin
                wb_ack_i = 1'b0; #1;
                if (w == 0) begin a0 = wb_adr_o; d0 = wb_dat_o; end
                if (fifo_rd || !wb_stb_o || wb_adr_o !== a0 ||
                    wb_dat_o !== d0) obs_bad++;
                @(negedge clk); t++;
            end
            wb_ack_i = 1'b1; #1;
            if (waits > 0 && (wb_adr_o !== a0 || wb_dat_o !== d0))
                obs_bad++;
            if (!wb_we_o || wb_sel_o !== 4'hF) obs_bad++;
            obs_adr[obs_n] = wb_adr_o;
            obs_dat[obs_n] = wb_dat_o;
            if (fifo_rd) obs_pops++;
            obs_n++;
            @(negedge clk); t++;
        end
        wb_ack_i = 1'b0; #1;
        obs_cyc = wb_cyc_o;
        obs_fd  = frame_done;
        obs_db  = done_buf;
    endtask

    task automatic test_reset;
        nRST = 1'b0; enable = 1'b0; fifo_level = '0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, fifo_rd} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_bus: cyc/stb/we/rd=%b want 0000",
                     {wb_cyc_o, wb_stb_o, wb_we_o, fifo_rd});
        end
        n_chk++;
        if (wb_adr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_adr: got %h want 0", wb_adr_o);
        end
        n_chk++;
        if ({frame_done, done_buf} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_done: got %b want 00",
                     {frame_done, done_buf});
        end
        nRST = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (wb_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_enable: cyc=%b want 0", wb_cyc_o);
        end
    endtask

    task automatic test_first_burst;
        enable = 1'b1; fifo_level = 7'd8;
        do_burst(0);
        n_chk++;
        if (obs_to !== 1'b0 || obs_n !== NB) begin
            n_fail++;
            $display("FAIL first_start: to=%b n=%0d want 0/8",
                     obs_to, obs_n);
        end
        for (int i = 0; i < NB; i++) begin
            n_chk++;
            if (obs_adr[i] !== B0 + 32'(4 * i) ||
                obs_dat[i] !== obs_d0 + 32'(i)) begin
                n_fail++;
                $display("FAIL first_word%0d: adr=%h dat=%h want %h/%h",
                         i, obs_adr[i], obs_dat[i],
                         B0 + 32'(4 * i), obs_d0 + 32'(i));
            end
        end
        n_chk++;
        if (obs_pops !== NB || obs_bad !== 0) begin
            n_fail++;
            $display("FAIL first_pops: pops=%0d bad=%0d want 8/0",
                     obs_pops, obs_bad);
        end
        n_chk++;
        if (obs_cyc !== 1'b0 || obs_fd !== 1'b0) begin
            n_fail++;
            $display("FAIL first_end: cyc=%b fd=%b want 0/0",
                     obs_cyc, obs_fd);
        end
    endtask

    task automatic test_level_threshold;
        int hits, t;
        hits = 0; t = 0;
        fifo_level = 7'd7;
        repeat (20) begin
            @(negedge clk); #1;
            if (wb_cyc_o || wb_stb_o) hits++;
        end
        n_chk++;
        if (hits !== 0) begin
            n_fail++;
            $display("FAIL level7_no_burst: got %0d cycles want 0", hits);
        end
        fifo_level = 7'd8;
        while (!wb_stb_o && t < 5) begin @(negedge clk); #1; t++; end
        n_chk++;
        if (!(wb_stb_o && t <= 2)) begin
            n_fail++;
            $display("FAIL level8_start: stb=%b after %0d want 1 by 2",
                     wb_stb_o, t);
        end
    endtask

    task automatic test_wait_states;
        do_burst(2);
        for (int i = 0; i < NB; i++) begin
            n_chk++;
            if (obs_adr[i] !== B0 + 32'(32 + 4 * i) ||
                obs_dat[i] !== obs_d0 + 32'(i)) begin
                n_fail++;
                $display("FAIL wait_word%0d: adr=%h dat=%h want %h/%h",
                         i, obs_adr[i], obs_dat[i],
                         B0 + 32'(32 + 4 * i), obs_d0 + 32'(i));
            end
        end
        n_chk++;
        if (obs_pops !== NB || obs_bad !== 0) begin
            n_fail++;
            $display("FAIL wait_pops: pops=%0d bad=%0d want 8/0",
                     obs_pops, obs_bad);
        end
        n_chk++;
        if (obs_cyc !== 1'b0 || obs_fd !== 1'b1 || obs_db !== 1'b0) begin
            n_fail++;
            $display("FAIL frame0_done: cyc=%b fd=%b db=%b want 0/1/0",
                     obs_cyc, obs_fd, obs_db);
        end
    endtask

    task automatic test_frame_done_pulse;
        @(negedge clk); #1;
        n_chk++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fd_pulse_width: fd=%b want 0", frame_done);
        end
    endtask

    task automatic test_double_buf;
        logic [31:0] fb;
        fb = DBL ? B1 : B0;
        do_burst(0);
        n_chk++;
        if (obs_adr[0] !== fb || obs_adr[NB-1] !== fb + 32'd28) begin
            n_fail++;
            $display("FAIL frame1_base: first=%h last=%h want %h/%h",
                     obs_adr[0], obs_adr[NB-1], fb, fb + 32'd28);
        end
        do_burst(0);
        n_chk++;
        if (obs_adr[0] !== fb + 32'd32 || obs_pops !== NB) begin
            n_fail++;
            $display("FAIL frame1_b2: adr=%h pops=%0d want %h/8",
                     obs_adr[0], obs_pops, fb + 32'd32);
        end
        n_chk++;
        if (obs_fd !== 1'b1 || obs_db !== DBL) begin
            n_fail++;
            $display("FAIL frame1_done: fd=%b db=%b want 1/%b",
                     obs_fd, obs_db, DBL);
        end
    endtask

    task automatic test_enable_drop;
        int hits;
        hits = 0;
        do_burst(0);
        n_chk++;
        if (obs_adr[0] !== B0 || obs_fd !== 1'b0) begin
            n_fail++;
            $display("FAIL frame2_b1: adr=%h fd=%b want %h/0",
                     obs_adr[0], obs_fd, B0);
        end
        enable = 1'b0;
        do_burst(0);
        n_chk++;
        if (obs_n !== NB || obs_adr[NB-1] !== B0 + 32'd60) begin
            n_fail++;
            $display("FAIL frame2_b2: n=%0d last=%h want 8/%h",
                     obs_n, obs_adr[NB-1], B0 + 32'd60);
        end
        n_chk++;
        if (obs_fd !== 1'b1) begin
            n_fail++;
            $display("FAIL frame2_done: fd=%b want 1", obs_fd);
        end
        repeat (10) begin
            @(negedge clk); #1;
            if (wb_stb_o) hits++;
        end
        n_chk++;
        if (hits !== 0) begin
            n_fail++;
            $display("FAIL idle_after_drop: got %0d stb want 0", hits);
        end
    endtask

    task automatic test_reset_mid_burst;
        int t;
        t = 0;
        enable = 1'b1;
        while (!wb_stb_o && t < 20) begin @(negedge clk); #1; t++; end
        n_chk++;
        if (wb_stb_o !== 1'b1 || wb_adr_o !== (DBL ? B1 : B0)) begin
            n_fail++;
            $display("FAIL frame3_start: stb=%b adr=%h want 1/%h",
                     wb_stb_o, wb_adr_o, DBL ? B1 : B0);
        end
        wb_ack_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (fifo_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_burst_rd: rd=%b want 1", fifo_rd);
        end
        nRST = 1'b0; #1;
        n_chk++;
        if ({wb_cyc_o, wb_stb_o, fifo_rd} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: cyc/stb/rd=%b want 000",
                     {wb_cyc_o, wb_stb_o, fifo_rd});
        end
        wb_ack_i = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        do_burst(0);
        for (int i = 0; i < NB; i++) begin
            n_chk++;
            if (obs_adr[i] !== B0 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL restart_word%0d: adr=%h want %h",
                         i, obs_adr[i], B0 + 32'(4 * i));
            end
        end
        n_chk++;
        if (obs_pops !== NB || obs_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_end: pops=%0d cyc=%b want 8/0",
                     obs_pops, obs_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_first_burst();
        test_level_threshold();
        test_wait_states();
        test_frame_done_pulse();
        test_double_buf();
        test_enable_drop();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
